ram_burst_reader: RTL

//   Read-side controller for the synchronous dual-port RAM used as line/frame buffer storage.
//   On a start command it reads LENGTH consecutive words from BASE_ADDR.
//   It drives the RAM read port (r_ena/r_addr, 1-cycle registered read latency).
//   It returns the words as a valid/ready stream through a 2-entry output FIFO, with no loss under backpressure.

---
 rtl/ram_burst_reader_if.sv | 25 ++
 rtl/ram_burst_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader_if.sv
// Valid/ready word stream carrying burst read data plus an end-of-command marker.
// Latency: none, wires only.
// Backpressure: the slave holds m_ready low to stall; the master keeps m_data/m_last stable while stalled.
interface ram_burst_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst reader: on start, reads length consecutive RAM words from base_addr and streams them out.
// Latency: start accepted at cycle 0 -> first RAM read at cycle 1 -> first m_valid at cycle 3; 1 word/cycle sustained.
// Backpressure: reads are credit-limited so occupancy plus the in-flight read never exceeds the 2-entry FIFO.
module ram_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_r_ena,
   output logic [ADDR_WIDTH-1:0] ram_r_addr,
   input  logic [DATA_WIDTH-1:0] ram_r_data,
   ram_burst_reader_if.master    m
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ADDR_WIDTH:0] REMAIN_ZERO = '0;
   localparam logic [ADDR_WIDTH:0] REMAIN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [1:0]            state;
   logic [ADDR_WIDTH:0]   remain;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  inflight;
   logic                  inflight_last;

   // 2-entry output FIFO storage
   logic [DATA_WIDTH-1:0] fifo_dat0;
   logic [DATA_WIDTH-1:0] fifo_dat1;
   logic                  fifo_lst0;
   logic                  fifo_lst1;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            occ;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            in_use;

   // The read issued last cycle returns data now; that is the only FIFO write source.
   assign push = inflight;
   assign pop  = m.m_valid & m.m_ready;

   // Slots committed after this cycle: stored words plus the returning read, minus the one leaving.
   // pop implies occ >= 1, so this never underflows.
   assign in_use = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign issue      = (state == S_RUN) && (remain != REMAIN_ZERO) && (in_use < 3'd2);
   assign ram_r_ena  = issue;
   assign ram_r_addr = addr;
   assign busy       = (state != S_IDLE);

   assign m.m_valid = (occ != 2'd0);
   assign m.m_data  = rd_ptr ? fifo_dat1 : fifo_dat0;
   assign m.m_last  = m.m_valid & (rd_ptr ? fifo_lst1 : fifo_lst0);

   // Command FSM, read address/count tracking, in-flight tag and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         remain        <= '0;
         addr          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done          <= 1'b0;
      end else begin
         done          <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remain == REMAIN_ONE);
         if (issue) begin
            addr   <= addr + 1'b1;
            remain <= remain - REMAIN_ONE;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr   <= base_addr;
                  remain <= length;
                  if (length == REMAIN_ZERO) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (issue && (remain == REMAIN_ONE)) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && m.m_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO write/read pointers and occupancy; the credit rule keeps occ <= 1 whenever a push lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_dat0 <= '0;
         fifo_dat1 <= '0;
         fifo_lst0 <= 1'b0;
         fifo_lst1 <= 1'b0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         occ       <= 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr) begin
               fifo_dat1 <= ram_r_data;
               fifo_lst1 <= inflight_last;
            end else begin
               fifo_dat0 <= ram_r_data;
               fifo_lst0 <= inflight_last;
            end
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule
